// File: rtl/vec3_norm_sched_if.sv
// Bus bundle between the vec3 normalize scheduler, its requesters and the shared normalize unit.
// Latency: none, signals only. Backpressure: request side only (req_ready_out); responses cannot stall.
// Ports: master = scheduler view (drives grants, unit issue, responses, busy); slave = environment view.
interface vec3_norm_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ-1:0][95:0] req_vec_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic                     unit_valid_out;
  logic [95:0]              unit_vec_out;
  logic [95:0]              unit_vec_in;
  logic [NUM_REQ-1:0]       rsp_valid_out;
  logic [95:0]              rsp_vec_out;
  logic                     busy_out;

  modport master (
    input  req_valid_in, req_vec_in, unit_vec_in,
    output req_ready_out, unit_valid_out, unit_vec_out,
           rsp_valid_out, rsp_vec_out, busy_out
  );

  modport slave (
    output req_valid_in, req_vec_in, unit_vec_in,
    input  req_ready_out, unit_valid_out, unit_vec_out,
           rsp_valid_out, rsp_vec_out, busy_out
  );
endinterface

// File: rtl/vec3_norm_sched.sv
// Round-robin scheduler sharing one pipelined vec3 normalize unit between NUM_REQ requesters.
// Latency: accept at T -> unit issue at T+1 -> response strobe at T+2+LATENCY.
// Backpressure: per-requester grant (one outstanding op each); responses have none and must be taken.
// Ports: clk_in / rst_n_in (async, active-low); bus (master modport) carries the request,
//   unit and response signals plus busy_out.
// Optional: VEC3_NORM_SCHED_STATS_EN adds stat_done_out, a 32-bit count of response cycles.
module vec3_norm_sched #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  vec3_norm_sched_if.master bus
`ifdef VEC3_NORM_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_done_out
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] pending;
  logic [IDW-1:0]     rr_ptr;
  tag_t               tags [0:LATENCY];

  logic               grant_any;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     cand;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_hit;
  logic [NUM_REQ-1:0] pending_nxt;

  logic               unit_valid_q;
  logic [95:0]        unit_vec_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [95:0]        rsp_vec_q;

  // Scan upward from rr_ptr with wrap; the first eligible requester wins.
  // Grants are suppressed while reset is asserted so nothing is handed out
  // that the cleared state would then lose.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDW'((int'(rr_ptr) + off) % NUM_REQ);
      if (!grant_any && bus.req_valid_in[cand] && !pending[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (!rst_n_in) begin
      grant_any = 1'b0;
    end
  end

  assign grant = grant_any ? (NUM_REQ'(1) << grant_id) : '0;

  // Tag at the last stage lines up with the unit result on unit_vec_in.
  assign rsp_hit = tags[LATENCY].vld ? (NUM_REQ'(1) << tags[LATENCY].id) : '0;

  // Set after clear: a re-accept on the response edge keeps the bit high.
  assign pending_nxt = (pending & ~rsp_hit) | grant;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending      <= '0;
      rr_ptr       <= '0;
      unit_valid_q <= 1'b0;
      unit_vec_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_vec_q    <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        tags[s] <= '0;
      end
    end else begin
      pending      <= pending_nxt;
      unit_valid_q <= grant_any;
      if (grant_any) begin
        unit_vec_q <= bus.req_vec_in[grant_id];
        rr_ptr     <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end
      tags[0] <= tag_t'{vld: grant_any, id: grant_id};
      for (int s = 1; s <= LATENCY; s++) begin
        tags[s] <= tags[s-1];
      end
      rsp_valid_q <= rsp_hit;
      if (tags[LATENCY].vld) begin
        rsp_vec_q <= bus.unit_vec_in;
      end
    end
  end

  assign bus.req_ready_out  = grant;
  assign bus.unit_valid_out = unit_valid_q;
  assign bus.unit_vec_out   = unit_vec_q;
  assign bus.rsp_valid_out  = rsp_valid_q;
  assign bus.rsp_vec_out    = rsp_vec_q;
  assign bus.busy_out       = |pending;

`ifdef VEC3_NORM_SCHED_STATS_EN
  logic [31:0] stat_q;

  // Counts cycles carrying a response; wraps naturally at 2^32.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_q <= '0;
    end else if (|rsp_valid_q) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_done_out = stat_q;
`endif

endmodule

// File: tb/tb_vec3_norm_sched.sv
// Directed bench for vec3_norm_sched with a fixed-latency model normalize unit.
// Latency under test: 10 cycles accept-to-response at NUM_REQ=4, LATENCY=8.
// Backpressure under test: grant rotation, pending skip, reset drop of in-flight results.
module tb_vec3_norm_sched;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 8;

  // Q16.16 components {x, y, z}: (3,0,4) normalizes to (0.6,0,0.8) truncated.
  localparam logic [95:0] V345 = {32'h0003_0000, 32'h0000_0000, 32'h0004_0000};
  localparam logic [95:0] V068 = {32'h0000_9999, 32'h0000_0000, 32'h0000_CCCC};

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  vec3_norm_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef VEC3_NORM_SCHED_STATS_EN
  logic [31:0] stat_done_out;
`endif

  vec3_norm_sched #(.NUM_REQ(NUM_REQ), .LATENCY(LAT)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
`ifdef VEC3_NORM_SCHED_STATS_EN
    ,
    .stat_done_out (stat_done_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Model unit: the 3-4-5 vector gets its true normalized value, anything
  // else is bit-inverted so routing errors are visible in the data.
  function automatic logic [95:0] unit_fn(input logic [95:0] v);
    return (v == V345) ? V068 : ~v;
  endfunction

  logic [95:0] pipe [LAT];
  always @(posedge clk_in) begin
    pipe[0] <= bus.unit_valid_out ? unit_fn(bus.unit_vec_out) : '0;
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign bus.unit_vec_in = pipe[LAT-1];

  // Operand of requester k in the round-robin phases, and its model result.
  function automatic logic [95:0] rr_vec(input int k);
    return {3{32'(k + 1)}};
  endfunction

  function automatic logic [95:0] onehot_rsp(input logic [3:0] oh);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < NUM_REQ; k++) if (oh[k]) r = ~rr_vec(k);
    return r;
  endfunction

  // Hand-derived cycle tables for the all-valid rotation, cycles 0..20.
  logic [3:0] rr_rdy [21] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
  logic [3:0] rr_rsp [21] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
  logic       rr_uv  [21] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Pending-skip tables, cycles 0..11 (req 2 alone at cycle 0, then 2 and 3).
  logic [3:0] ps_rdy [12] = '{4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8};
  logic [3:0] ps_rsp [12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8};

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid_in = '0;
    rst_n_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  initial begin
    bus.req_valid_in = '1;
    bus.req_vec_in   = '0;
    #2;
    chk("rst_ready",      96'(bus.req_ready_out),  96'h0);
    chk("rst_unit_valid", 96'(bus.unit_valid_out), 96'h0);
    chk("rst_unit_vec",   bus.unit_vec_out,        96'h0);
    chk("rst_rsp_valid",  96'(bus.rsp_valid_out),  96'h0);
    chk("rst_rsp_vec",    bus.rsp_vec_out,         96'h0);
    chk("rst_busy",       96'(bus.busy_out),       96'h0);
`ifdef VEC3_NORM_SCHED_STATS_EN
    chk("rst_stat",       96'(stat_done_out),      96'h0);
`endif
    do_reset();

    // Single request from requester 1.
    bus.req_vec_in[1] = V345;
    bus.req_valid_in  = 4'b0010;
    #1;
    chk("single_ready_c0", 96'(bus.req_ready_out), 96'h2);
    tick();
    bus.req_valid_in = '0;
    #1;
    chk("single_uv_c1",   96'(bus.unit_valid_out), 96'h1);
    chk("single_uvec_c1", bus.unit_vec_out,        V345);
    chk("single_busy_c1", 96'(bus.busy_out),       96'h1);
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk("single_rsp_idle", 96'(bus.rsp_valid_out),  96'h0);
      chk("single_busy_mid", 96'(bus.busy_out),       96'h1);
      chk("single_uv_idle",  96'(bus.unit_valid_out), 96'h0);
      chk("single_uvec_hold", bus.unit_vec_out,       V345);
    end
    tick();
    chk("single_rsp_c10",  96'(bus.rsp_valid_out), 96'h2);
    chk("single_rvec_c10", bus.rsp_vec_out,        V068);
    tick();
    chk("single_rsp_c11",  96'(bus.rsp_valid_out), 96'h0);
    chk("single_busy_c11", 96'(bus.busy_out),      96'h0);

    // All requesters valid continuously: rotation, then re-accept on response.
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) bus.req_vec_in[k] = rr_vec(k);
    bus.req_valid_in = 4'b1111;
    for (int c = 0; c <= 20; c++) begin
      #1;
      chk("rr_ready", 96'(bus.req_ready_out),  96'(rr_rdy[c]));
      chk("rr_rsp",   96'(bus.rsp_valid_out),  96'(rr_rsp[c]));
      chk("rr_uv",    96'(bus.unit_valid_out), 96'(rr_uv[c]));
      if (rr_rsp[c] != 4'h0) chk("rr_rvec", bus.rsp_vec_out, onehot_rsp(rr_rsp[c]));
      tick();
    end
    #1;
    chk("rr_busy_c21", 96'(bus.busy_out), 96'h1);
`ifdef VEC3_NORM_SCHED_STATS_EN
    chk("stat_after_5", 96'(stat_done_out), 96'd5);
`endif

    // Requester 2 pending: skipped although valid, re-granted on its response cycle.
    do_reset();
`ifdef VEC3_NORM_SCHED_STATS_EN
    chk("stat_after_rst", 96'(stat_done_out), 96'h0);
`endif
    bus.req_valid_in = 4'b0100;
    for (int c = 0; c <= 11; c++) begin
      #1;
      chk("skip_ready", 96'(bus.req_ready_out), 96'(ps_rdy[c]));
      chk("skip_rsp",   96'(bus.rsp_valid_out), 96'(ps_rsp[c]));
      tick();
      bus.req_valid_in = 4'b1100;
    end

    // Reset mid-flight after three grants; in-flight results must be dropped.
    do_reset();
    bus.req_valid_in = 4'b1111;
    tick();
    tick();
    tick();
    #1;
    chk("mid_ready_c3", 96'(bus.req_ready_out),  96'h8);
    chk("mid_uv_c3",    96'(bus.unit_valid_out), 96'h1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_ready", 96'(bus.req_ready_out),  96'h0);
    chk("mid_rst_uv",    96'(bus.unit_valid_out), 96'h0);
    chk("mid_rst_uvec",  bus.unit_vec_out,        96'h0);
    chk("mid_rst_rsp",   96'(bus.rsp_valid_out),  96'h0);
    chk("mid_rst_rvec",  bus.rsp_vec_out,         96'h0);
    chk("mid_rst_busy",  96'(bus.busy_out),       96'h0);
    tick();
    rst_n_in = 1'b1;
    bus.req_valid_in = '0;
    for (int c = 4; c <= 20; c++) begin
      #1;
      chk("mid_no_rsp",  96'(bus.rsp_valid_out), 96'h0);
      chk("mid_no_busy", 96'(bus.busy_out),      96'h0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
